wbgpio_arbiter: RTL and testbench
=================================

// Module: wbgpio_arbiter
// PURPOSE
//  Two-master round-robin arbiter sharing one pipelined Wishbone slave (the GPIO port).
//  Master A is the CPU bus and master B is the debug bus. The winner holds the grant for
//  its whole CYC.
//  Sits between the bus masters and the GPIO register slave. Write-mask semantics pass through.
// PARAMETERS
//  DW       32   data width
//  TIMEOUT  255  cycles in a grant without slave ack before forced release (TIMEOUT_EN only)
// PORTS
//  i_clk             in   1   system clock
//  i_reset_n         in   1   async reset, active low
//  i_a_cyc,i_a_stb,i_a_we  in 1  master A bus
//  i_a_data          in   DW  master A write data
//  o_a_stall,o_a_ack,o_a_err  out 1  master A handshake
//  o_a_data          out  DW  read data to A
//  i_b_* / o_b_*     --   --  master B, identical to A
//  o_s_cyc,o_s_stb,o_s_we  out 1  slave bus
//  o_s_data          out  DW  slave write data
//  i_s_data          in   DW  slave read data
//  i_s_ack,i_s_stall in   1   slave handshake
// BEHAVIOUR
//  - States: IDLE, GNT_A, GNT_B (registered); last-served flag `last` (registered).
//  - Reset (async): state=IDLE, last=B (A wins the first tie), counter=0.
//    All o_s_*, o_*_ack and o_*_err are 0; o_*_stall is 1.
//  - IDLE: if only one cyc is high, grant it next edge.
//    If both are high, grant the master != last. No slave access happens in IDLE.
//  - GNT_X with i_x_cyc high: hold the grant. With i_x_cyc low: release at that edge.
//    If the other master's cyc is high, go directly to GNT_other; else go to IDLE.
//    `last` <= X on release.
//  - Slave outputs are a combinational mux on the registered state.
//    o_s_cyc=i_x_cyc and o_s_stb=i_x_stb in GNT_X; o_s_we and o_s_data follow X.
//    In IDLE all are 0.
//  - Granted master: o_x_stall=i_s_stall, o_x_ack=i_s_ack, o_x_data=i_s_data.
//  - Non-granted master: stall=1, ack=0, err=0. o_*_data always = i_s_data.
//  - Added latency: 1 cycle from cyc rise to first slave stb (grant register).
//    Zero latency on the ack/data return path.
//  - A slave ack that arrives after release is not routed to either master.
//    Masters must not drop cyc with acks outstanding.
//  - Simultaneous release by the granted master and request by the other: handoff in 1 edge,
//    no IDLE cycle.
// CONFIGURATION
//  - WBGPIO_ARB_TIMEOUT_EN defined:
//    - Counter ($clog2(TIMEOUT+1) bits) clears on grant change and on i_s_ack.
//      It increments each cycle in GNT_X with i_x_cyc high.
//    - On reaching TIMEOUT: o_x_err=1 for exactly one cycle; state goes to IDLE at that edge;
//      o_s_cyc drops.
//    - Master X is locked out of re-grant until it has dropped cyc for >=1 cycle.
//  - Not defined: no counter; o_a_err=o_b_err=0 constantly; the TIMEOUT parameter is ignored.
// TESTING
//  1. A alone writes 0x0001_0001 -> o_s_stb 1 cycle after i_a_cyc rises, o_s_data=0x00010001;
//     i_s_ack -> o_a_ack same cycle; o_b_ack stays 0.
//  2. A and B raise cyc together after reset -> GNT_A. A drops cyc -> GNT_B next edge.
//     Both re-request after B releases -> GNT_A (round robin).
//  3. B holds cyc for 10 cycles while A strobes -> o_a_stall=1 throughout, o_s_* follows B.
//     A is granted on the edge B drops cyc.
//  4. Assert i_reset_n=0 mid-transfer in GNT_B -> o_s_cyc=0, o_b_ack=0 immediately, no clock needed.
//     After release -> A wins the first tie.
//  5. With TIMEOUT_EN, TIMEOUT=8, slave never acks: o_a_err pulses 8 cycles after grant and
//     o_s_cyc drops; B, if pending, is granted next. A is not regranted until it drops cyc.
//  6. i_s_stall=1 for 3 cycles during A's grant -> o_a_stall mirrors it; o_b_stall stays 1.

Source files
------------

// File: rtl/wbgpio_arbiter.sv
// Two-master round-robin arbiter sharing one pipelined Wishbone slave (GPIO port).
// Optional grant watchdog is enabled by defining WBGPIO_ARB_TIMEOUT_EN.
module wbgpio_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  // master A (CPU)
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_stall,
  output logic          o_a_ack,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  // master B (debug)
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_stall,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  // slave
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [DW-1:0] o_s_data,
  input  logic [DW-1:0] i_s_data,
  input  logic          i_s_ack,
  input  logic          i_s_stall
);

  typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

  state_e state_q, state_d;
  logic   last_b_q, last_b_d;  // set when B was the last master served
  logic   req_a, req_b;
  logic   tmo_a, tmo_b;

`ifdef WBGPIO_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_a_q, lock_a_d, lock_b_q, lock_b_d;
  logic          tmo;

  assign tmo   = (state_q != StIdle) && (cnt_q == CW'(TIMEOUT));
  assign tmo_a = tmo && (state_q == StGntA);
  assign tmo_b = tmo && (state_q == StGntB);
  // A timed-out master stays locked out until it drops cyc for a cycle.
  assign req_a = i_a_cyc & ~lock_a_q;
  assign req_b = i_b_cyc & ~lock_b_q;

  always_comb begin
    cnt_d    = cnt_q;
    lock_a_d = tmo_a | (lock_a_q & i_a_cyc);
    lock_b_d = tmo_b | (lock_b_q & i_b_cyc);
    if ((state_d != state_q) || i_s_ack) begin
      cnt_d = '0;
    end else if ((state_q == StGntA && i_a_cyc) || (state_q == StGntB && i_b_cyc)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q    <= '0;
      lock_a_q <= 1'b0;
      lock_b_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lock_a_q <= lock_a_d;
      lock_b_q <= lock_b_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign tmo_a          = 1'b0;
  assign tmo_b          = 1'b0;
  assign req_a          = i_a_cyc;
  assign req_b          = i_b_cyc;
`endif

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = last_b_q ? StGntA : StGntB;
        end else if (req_a) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA: begin
        if (tmo_a) begin
          state_d  = StIdle;
          last_b_d = 1'b0;
        end else if (!i_a_cyc) begin
          state_d  = req_b ? StGntB : StIdle;
          last_b_d = 1'b0;
        end
      end
      StGntB: begin
        if (tmo_b) begin
          state_d  = StIdle;
          last_b_d = 1'b1;
        end else if (!i_b_cyc) begin
          state_d  = req_a ? StGntA : StIdle;
          last_b_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
    end
  end

  // Routing is a pure mux on the registered grant: zero latency on the return path.
  always_comb begin
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = 1'b0;
    o_s_data  = '0;
    o_a_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_b_stall = 1'b1;
    o_b_ack   = 1'b0;
    unique case (state_q)
      StGntA: begin
        o_s_cyc   = i_a_cyc;
        o_s_stb   = i_a_stb;
        o_s_we    = i_a_we;
        o_s_data  = i_a_data;
        o_a_stall = i_s_stall;
        o_a_ack   = i_s_ack;
      end
      StGntB: begin
        o_s_cyc   = i_b_cyc;
        o_s_stb   = i_b_stb;
        o_s_we    = i_b_we;
        o_s_data  = i_b_data;
        o_b_stall = i_s_stall;
        o_b_ack   = i_s_ack;
      end
      default: ;
    endcase
  end

  assign o_a_err  = tmo_a;
  assign o_b_err  = tmo_b;
  assign o_a_data = i_s_data;
  assign o_b_data = i_s_data;

endmodule

// File: tb/tb_wbgpio_arbiter.sv
// Self-checking bench for wbgpio_arbiter: directed scenarios plus a randomized run
// against a transaction-level ownership model.
module tb_wbgpio_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
`ifdef WBGPIO_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we;
  logic [DW-1:0] i_a_data, i_b_data, i_s_data;
  logic          i_s_ack, i_s_stall;
  logic          o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
  logic          o_s_cyc, o_s_stb, o_s_we;
  logic [DW-1:0] o_a_data, o_b_data, o_s_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  wbgpio_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_data(i_a_data),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_data(i_b_data),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_data(o_s_data),
    .i_s_data(i_s_data), .i_s_ack(i_s_ack), .i_s_stall(i_s_stall)
  );

  task automatic idle_inputs();
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_data = 32'hA0A0_0000;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_data = 32'hB0B0_0000;
    i_s_ack = 0; i_s_stall = 0; i_s_data = 32'h5A5A_5A5A;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n = 0;
    idle_inputs();
    @(negedge i_clk);
    i_reset_n = 1;
  endtask

  task automatic test_reset();
    i_reset_n = 0;
    idle_inputs();
    i_a_cyc = 1; i_a_stb = 1; i_s_ack = 1; i_b_cyc = 1;
    #2;
    n_cmp++; if ({o_s_cyc, o_s_stb, o_s_we} !== 3'b000) begin
      n_err++; $display("FAIL reset_slave: got %b want 000", {o_s_cyc, o_s_stb, o_s_we}); end
    n_cmp++; if ({o_a_stall, o_b_stall} !== 2'b11) begin
      n_err++; $display("FAIL reset_stall: got %b want 11", {o_a_stall, o_b_stall}); end
    n_cmp++; if ({o_a_ack, o_b_ack, o_a_err, o_b_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ack_err: got %b want 0000",
                        {o_a_ack, o_b_ack, o_a_err, o_b_err}); end
    @(negedge i_clk);
    idle_inputs();
    @(negedge i_clk);
    i_reset_n = 1;
  endtask

  task automatic test_single_write();
    @(negedge i_clk);
    i_a_cyc = 1; i_a_stb = 1; i_a_we = 1; i_a_data = 32'h0001_0001;
    #1;
    n_cmp++; if (o_s_stb !== 1'b0) begin
      n_err++; $display("FAIL t1_stb_latency: got %b want 0", o_s_stb); end
    @(posedge i_clk); #1;
    n_cmp++; if ({o_s_cyc, o_s_stb, o_s_we, o_s_data} !== {3'b111, 32'h0001_0001}) begin
      n_err++; $display("FAIL t1_slave_bus: got %b_%h want 111_00010001",
                        {o_s_cyc, o_s_stb, o_s_we}, o_s_data); end
    i_s_ack = 1; i_s_data = 32'hCAFE_0123;
    #1;
    n_cmp++; if ({o_a_ack, o_b_ack, o_a_data} !== {2'b10, 32'hCAFE_0123}) begin
      n_err++; $display("FAIL t1_ack: got %b_%h want 10_cafe0123", {o_a_ack, o_b_ack}, o_a_data); end
    @(negedge i_clk);
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_s_ack = 0;
    @(posedge i_clk); #1;
    n_cmp++; if ({o_s_cyc, o_a_stall} !== 2'b01) begin
      n_err++; $display("FAIL t1_release: got %b want 01", {o_s_cyc, o_a_stall}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge i_clk);
    i_a_cyc = 1; i_b_cyc = 1; i_a_data = 32'h1111_1111; i_b_data = 32'h2222_2222;
    @(posedge i_clk); #1;
    n_cmp++; if ({o_s_data, o_a_stall, o_b_stall} !== {32'h1111_1111, 2'b01}) begin
      n_err++; $display("FAIL t2_first_tie: got %h_%b want 11111111_01",
                        o_s_data, {o_a_stall, o_b_stall}); end
    @(negedge i_clk); i_a_cyc = 0;
    @(posedge i_clk); #1;
    n_cmp++; if ({o_s_data, o_s_cyc, o_b_stall} !== {32'h2222_2222, 2'b10}) begin
      n_err++; $display("FAIL t2_handoff_b: got %h_%b want 22222222_10",
                        o_s_data, {o_s_cyc, o_b_stall}); end
    @(negedge i_clk); i_b_cyc = 0;
    @(negedge i_clk); i_a_cyc = 1; i_b_cyc = 1;
    @(posedge i_clk); #1;
    n_cmp++; if (o_s_data !== 32'h1111_1111) begin
      n_err++; $display("FAIL t2_rr_a: got %h want 11111111", o_s_data); end
    @(negedge i_clk); i_a_cyc = 0; i_b_cyc = 0;
    @(negedge i_clk); i_a_cyc = 1; i_b_cyc = 1;
    @(posedge i_clk); #1;
    n_cmp++; if (o_s_data !== 32'h2222_2222) begin
      n_err++; $display("FAIL t2_rr_b: got %h want 22222222", o_s_data); end
    @(negedge i_clk); idle_inputs();
  endtask

  task automatic test_hold();
    logic stb;
    @(negedge i_clk);
    i_b_cyc = 1; i_b_stb = 1; i_b_data = 32'hBEEF_0000;
    @(posedge i_clk); #1;
    i_a_cyc = 1; i_a_stb = 1; i_a_data = 32'hA5A5_0000;
    for (int i = 0; i < 10; i++) begin
      stb = 1'($urandom_range(0, 1));
      i_b_stb = stb; i_b_data = 32'hBEEF_0000 + i;
      #1;
      n_cmp++; if ({o_a_stall, o_s_cyc, o_s_stb, o_s_data} !== {2'b11, stb, 32'hBEEF_0000 + i})
      begin
        n_err++; $display("FAIL t3_hold_b: got %b_%h want 11%b_%h", {o_a_stall, o_s_cyc, o_s_stb},
                          o_s_data, stb, 32'hBEEF_0000 + i); end
      @(posedge i_clk); #1;
    end
    @(negedge i_clk); i_b_cyc = 0; i_b_stb = 0;
    @(posedge i_clk); #1;
    n_cmp++; if ({o_s_data, o_a_stall, o_b_stall} !== {32'hA5A5_0000, 2'b01}) begin
      n_err++; $display("FAIL t3_grant_a: got %h_%b want a5a50000_01",
                        o_s_data, {o_a_stall, o_b_stall}); end
    @(negedge i_clk); idle_inputs();
  endtask

  task automatic test_async_reset();
    @(negedge i_clk); i_a_cyc = 1;
    @(negedge i_clk); i_a_cyc = 0;
    @(negedge i_clk); i_b_cyc = 1; i_b_stb = 1;
    @(posedge i_clk); #1;
    i_s_ack = 1;
    #1;
    n_cmp++; if (o_b_ack !== 1'b1) begin
      n_err++; $display("FAIL t4_pre_ack: got %b want 1", o_b_ack); end
    #1; i_reset_n = 0;
    #1;
    n_cmp++; if ({o_s_cyc, o_b_ack, o_b_stall} !== 3'b001) begin
      n_err++; $display("FAIL t4_async: got %b want 001", {o_s_cyc, o_b_ack, o_b_stall}); end
    i_s_ack = 0; i_a_cyc = 1;
    @(negedge i_clk); i_reset_n = 1;
    @(posedge i_clk); #1;
    n_cmp++; if ({o_a_stall, o_b_stall} !== 2'b01) begin
      n_err++; $display("FAIL t4_tie_after_reset: got %b want 01", {o_a_stall, o_b_stall}); end
    @(negedge i_clk); idle_inputs();
  endtask

  task automatic test_stall();
    @(negedge i_clk); i_a_cyc = 1; i_a_stb = 1;
    @(posedge i_clk); #1;
    i_b_cyc = 1;
    for (int i = 0; i < 4; i++) begin
      i_s_stall = (i < 3);
      #1;
      n_cmp++; if ({o_a_stall, o_b_stall} !== {1'(i < 3), 1'b1}) begin
        n_err++; $display("FAIL t6_stall[%0d]: got %b want %b1", i, {o_a_stall, o_b_stall},
                          1'(i < 3)); end
      @(posedge i_clk); #1;
    end
    @(negedge i_clk); idle_inputs();
    @(negedge i_clk);
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge i_clk); i_a_cyc = 1; i_a_stb = 1;
    @(posedge i_clk); #1;
    for (int k = 0; k < int'(TO); k++) begin
      if (k == 2) i_b_cyc = 1;
      n_cmp++; if ({o_a_err, o_s_cyc} !== 2'b01) begin
        n_err++; $display("FAIL t5_pre_tmo[%0d]: got %b want 01", k, {o_a_err, o_s_cyc}); end
      @(posedge i_clk); #1;
    end
    n_cmp++; if ({o_a_err, o_b_err} !== 2'b10) begin
      n_err++; $display("FAIL t5_err_pulse: got %b want 10", {o_a_err, o_b_err}); end
    @(posedge i_clk); #1;
    n_cmp++; if ({o_a_err, o_s_cyc} !== 2'b00) begin
      n_err++; $display("FAIL t5_release: got %b want 00", {o_a_err, o_s_cyc}); end
    @(posedge i_clk); #1;
    n_cmp++; if ({o_s_data, o_a_stall, o_b_stall} !== {32'hB0B0_0000, 2'b10}) begin
      n_err++; $display("FAIL t5_b_next: got %h_%b want b0b00000_10",
                        o_s_data, {o_a_stall, o_b_stall}); end
    @(negedge i_clk); i_b_cyc = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      n_cmp++; if ({o_s_cyc, o_a_stall} !== 2'b01) begin
        n_err++; $display("FAIL t5_locked[%0d]: got %b want 01", k, {o_s_cyc, o_a_stall}); end
    end
    @(negedge i_clk); i_a_cyc = 0;
    @(negedge i_clk); i_a_cyc = 1;
    @(posedge i_clk); #1;
    n_cmp++; if ({o_s_cyc, o_a_stall} !== 2'b10) begin
      n_err++; $display("FAIL t5_unlock: got %b want 10", {o_s_cyc, o_a_stall}); end
    @(negedge i_clk); idle_inputs();
  endtask

  // Model: who owns the slave, who was served last, cycles without ack, lockouts.
  task automatic test_random();
    int owner = 0;
    int last = 2;
    int cnt = 0;
    bit lock_a = 0, lock_b = 0;
    bit ra, rb, tmo;
    int nxt;
    logic [34:0] exp_s;
    logic [34:0] exp_a, exp_b;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge i_clk);
      if ($urandom_range(0, 4) == 0) i_a_cyc = ~i_a_cyc;
      if ($urandom_range(0, 4) == 0) i_b_cyc = ~i_b_cyc;
      i_a_stb = 1'($urandom); i_a_we = 1'($urandom); i_a_data = $urandom;
      i_b_stb = 1'($urandom); i_b_we = 1'($urandom); i_b_data = $urandom;
      i_s_ack = ($urandom_range(0, 3) == 0); i_s_stall = 1'($urandom); i_s_data = $urandom;
      #1;
      tmo = TMO_EN && (owner != 0) && (cnt == int'(TO));
      if (owner == 1) begin
        exp_s = {i_a_cyc, i_a_stb, i_a_we, i_a_data};
        exp_a = {i_s_stall, i_s_ack, tmo, i_s_data};
        exp_b = {3'b100, i_s_data};
      end else if (owner == 2) begin
        exp_s = {i_b_cyc, i_b_stb, i_b_we, i_b_data};
        exp_a = {3'b100, i_s_data};
        exp_b = {i_s_stall, i_s_ack, tmo, i_s_data};
      end else begin
        exp_s = '0;
        exp_a = {3'b100, i_s_data};
        exp_b = {3'b100, i_s_data};
      end
      n_cmp++; if ({o_s_cyc, o_s_stb, o_s_we, o_s_data} !== exp_s) begin
        n_err++; $display("FAIL rnd_slave[%0d]: got %h want %h", cyc,
                          {o_s_cyc, o_s_stb, o_s_we, o_s_data}, exp_s); end
      n_cmp++; if ({o_a_stall, o_a_ack, o_a_err, o_a_data} !== exp_a) begin
        n_err++; $display("FAIL rnd_a[%0d]: got %h want %h", cyc,
                          {o_a_stall, o_a_ack, o_a_err, o_a_data}, exp_a); end
      n_cmp++; if ({o_b_stall, o_b_ack, o_b_err, o_b_data} !== exp_b) begin
        n_err++; $display("FAIL rnd_b[%0d]: got %h want %h", cyc,
                          {o_b_stall, o_b_ack, o_b_err, o_b_data}, exp_b); end
      @(posedge i_clk);
      ra = i_a_cyc && !lock_a;
      rb = i_b_cyc && !lock_b;
      nxt = owner;
      if (owner == 0) begin
        if (ra && rb) nxt = (last == 2) ? 1 : 2;
        else if (ra) nxt = 1;
        else if (rb) nxt = 2;
      end else if (tmo) begin
        nxt = 0; last = owner;
      end else if (owner == 1 && !i_a_cyc) begin
        nxt = rb ? 2 : 0; last = 1;
      end else if (owner == 2 && !i_b_cyc) begin
        nxt = ra ? 1 : 0; last = 2;
      end
      lock_a = (tmo && owner == 1) || (lock_a && i_a_cyc);
      lock_b = (tmo && owner == 2) || (lock_b && i_b_cyc);
      if (nxt != owner || i_s_ack) cnt = 0;
      else if ((owner == 1 && i_a_cyc) || (owner == 2 && i_b_cyc)) cnt++;
      owner = nxt;
    end
    @(negedge i_clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_hold();
    test_async_reset();
    test_stall();
`ifdef WBGPIO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
